lcd_timing_engine: RTL
======================

LCD_TIMING_ENGINE -- requirements
Module: lcd_timing_engine

Interface
REQ-001 Parameter H_ACTIVE, 480, visible pixels per line.
REQ-002 Parameter H_BLANK, 45, non-DE pixel clocks per line, at line start.
REQ-003 Parameter V_ACTIVE, 272, visible lines per frame.
REQ-004 Parameter V_BLANK, 16, non-DE lines per frame, at frame start.
REQ-005 Parameter PCLK_HALF, 12, clk cycles per tft_clk half-period; minimum 2.
REQ-006 Parameter T_EN_DISP, 10000, clk cycles from tft_en high to tft_display high.
REQ-007 Parameter T_DISP_BL, 32000000, clk cycles from tft_display high to backlight on.
REQ-008 Parameter PWM_PRESC, 16, clk cycles per PWM phase step; 256 steps per period.
REQ-009 Parameter ADDR_W, 17, framebuffer address width; must hold H_ACTIVE*V_ACTIVE-1.
REQ-010 Ports, one per line, clock and reset first:
 clk  in  1  system clock.
 rst_n  in  1  asynchronous active-low reset.
 enable  in  1  high: power up and run panel; low: power down.
 bl_duty  in  8  backlight duty; 0 = off, 255 = constant on.
 fmt  in  1  0 = RGB565, 1 = RGB332 in fb_data[7:0].
 fb_data  in  16  framebuffer read data, valid 1 clk after fb_addr.
 fb_addr  out  ADDR_W  framebuffer read address.
 tft_r, tft_g, tft_b  out  8 each  pixel colour.
 tft_clk  out  1  panel pixel clock.
 tft_de  out  1  data enable.
 tft_en  out  1  panel power enable.
 tft_display  out  1  display on.
 led_en  out  1  backlight PWM.
 frame_start  out  1  one-clk pulse at first pixel tick of each frame.
 vblank  out  1  high while v_count < V_BLANK.
 ready  out  1  high in RUN.

Function
REQ-011 Sequencer states: OFF, EN_WAIT, DISP_WAIT, RUN, SHUT_BL, SHUT_DISP.
REQ-012 OFF->EN_WAIT on enable=1; tft_en rises on entry; after T_EN_DISP clk -> DISP_WAIT with tft_display=1 and tft_clk toggling; after T_DISP_BL clk -> RUN.
REQ-013 enable=0 in any non-OFF state: led_en=0, tft_de=0, RGB=0 next clk, go SHUT_BL; after T_EN_DISP clk tft_display=0 -> SHUT_DISP; after T_EN_DISP clk tft_en=0, tft_clk=0 -> OFF.
REQ-014 enable=1 in a SHUT state: complete shutdown to OFF, then restart.
REQ-015 tft_clk toggles every PCLK_HALF clk in DISP_WAIT and RUN; fall tick = clk cycle where tft_clk is driven 1->0.
REQ-016 h_count 0..H_BLANK+H_ACTIVE-1 and v_count 0..V_BLANK+V_ACTIVE-1 advance on fall ticks in RUN only; h wraps to 0 and increments v; v wraps to 0.
REQ-017 tft_de, RGB, frame_start, vblank update on fall ticks, so stable at panel rising edge.
REQ-018 tft_de = (h_count >= H_BLANK) and (v_count >= V_BLANK); RGB = 0 when tft_de = 0.
REQ-019 fb_addr issued on the rise tick preceding the pixel's fall tick; linear, 0 at first active pixel, +1 per active pixel, never exceeds H_ACTIVE*V_ACTIVE-1; held during blanking.
REQ-020 fmt=0: r={d[15:11],d[15:13]}, g={d[10:5],d[10:9]}, b={d[4:0],d[4:2]}.
REQ-021 fmt=1: r={d[7:5],d[7:5],d[7:6]}, g={d[4:2],d[4:2],d[4:3]}, b={d[1:0]x4}.
REQ-022 fmt and bl_duty sampled only at frame_start; changes mid-frame take effect next frame.
REQ-023 PWM: 8-bit phase advances every PWM_PRESC clk in RUN; led_en = (phase < duty); duty 255 forces led_en constantly 1.
REQ-024 ready=1 exactly in RUN.

Reset
REQ-025 rst_n=0 asynchronously forces OFF; all outputs, counters, fb_addr and the PWM phase clear to 0; first transition occurs no earlier than the second clk edge after release.

Structure
REQ-026 Package lcd_pkg holds the state enum and default timing constants.
REQ-027 Sub-module lcd_pwm (prescaler + phase + compare) is instantiated once.

Verification (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1, PCLK_HALF=2, T_EN_DISP=5, T_DISP_BL=10, PWM_PRESC=1)
REQ-028 Release reset with enable=1 -> tft_en at clk 1, tft_display 5 clk later, ready 10 clk after that.
REQ-029 Run 2 frames -> frame period 24 pixel ticks; tft_de high for 4 ticks on lines 1..3; fb_addr sequences 0..11.
REQ-030 fb_data=16'hF800, fmt=0 -> RGB = FF/00/00; fmt=1 with 16'h00E0 -> RGB = FF/00/00 from the next frame only.
REQ-031 bl_duty=64 -> led_en high for 64 of 256 clk; bl_duty=255 -> constant high; bl_duty=0 -> constant low.
REQ-032 Drop enable mid-line -> led_en, tft_de, RGB = 0 next clk; tft_display low after 5 clk; tft_en low after 5 more clk; assert rst_n=0 mid-frame -> all outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, default panel timing and the pixel format expander
// for the LCD timing engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_EN_WAIT,
    ST_DISP_WAIT,
    ST_RUN,
    ST_SHUT_BL,
    ST_SHUT_DISP
  } lcd_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int DEF_H_ACTIVE  = 480;
  localparam int DEF_H_BLANK   = 45;
  localparam int DEF_V_ACTIVE  = 272;
  localparam int DEF_V_BLANK   = 16;
  localparam int DEF_PCLK_HALF = 12;
  localparam int DEF_T_EN_DISP = 10000;
  localparam int DEF_T_DISP_BL = 32000000;
  localparam int DEF_PWM_PRESC = 16;
  localparam int DEF_ADDR_W    = 17;

  // Bit replication fills the low bits so full-scale inputs reach 8'hFF.
  function automatic rgb_t px_expand(input logic fmt, input logic [15:0] d);
    rgb_t p;
    p = '0;
    if (fmt) begin
      p.r = {d[7:5], d[7:5], d[7:6]};
      p.g = {d[4:2], d[4:2], d[4:3]};
      p.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
    end else begin
      p.r = {d[15:11], d[15:13]};
      p.g = {d[10:5], d[10:9]};
      p.b = {d[4:0], d[4:2]};
    end
    return p;
  endfunction

endpackage

// File: rtl/lcd_pwm.sv
// Backlight PWM: prescaler, free-running 8-bit phase and duty compare.
module lcd_pwm #(
  parameter int PRESC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] duty,
  output logic       led_en
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESC - 1);

  logic [PW-1:0] pre;
  logic [7:0]    phase;
  logic          step;

  assign step = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      phase <= '0;
    end else if (!run) begin
      pre   <= '0;
      phase <= '0;
    end else begin
      pre <= step ? '0 : pre + 1'b1;
      if (step) phase <= phase + 8'd1;
    end
  end

  // Full-scale duty must never drop, so it bypasses the compare.
  assign led_en = run & ((duty == 8'hFF) | (phase < duty));

endmodule

// File: rtl/lcd_timing_engine.sv
// LCD panel timing engine: power sequencing, pixel clock, raster timing,
// framebuffer fetch and backlight PWM for a parallel-RGB TFT.
module lcd_timing_engine
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_BLANK   = DEF_H_BLANK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_BLANK   = DEF_V_BLANK,
  parameter int PCLK_HALF = DEF_PCLK_HALF,
  parameter int T_EN_DISP = DEF_T_EN_DISP,
  parameter int T_DISP_BL = DEF_T_DISP_BL,
  parameter int PWM_PRESC = DEF_PWM_PRESC,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [7:0]        bl_duty,
  input  logic              fmt,
  input  logic [15:0]       fb_data,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        tft_r,
  output logic [7:0]        tft_g,
  output logic [7:0]        tft_b,
  output logic              tft_clk,
  output logic              tft_de,
  output logic              tft_en,
  output logic              tft_display,
  output logic              led_en,
  output logic              frame_start,
  output logic              vblank,
  output logic              ready
);

  localparam int H_TOT = H_BLANK + H_ACTIVE;
  localparam int V_TOT = V_BLANK + V_ACTIVE;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int PDW   = $clog2(PCLK_HALF);

  localparam logic [HW-1:0]  H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0]  H_BLK   = HW'(H_BLANK);
  localparam logic [VW-1:0]  V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0]  V_BLK   = VW'(V_BLANK);
  localparam logic [PDW-1:0] PD_LAST = PDW'(PCLK_HALF - 1);
  localparam logic [31:0]    T_ED    = 32'(T_EN_DISP - 1);
  localparam logic [31:0]    T_DB    = 32'(T_DISP_BL - 1);

  lcd_state_e state, state_nxt;
  logic        armed;
  logic [31:0] tmr;

  // armed delays the first transition by one edge after reset release.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:       if (enable) state_nxt = ST_EN_WAIT;
      ST_EN_WAIT:   if (!enable) state_nxt = ST_SHUT_BL;
                    else if (tmr == T_ED) state_nxt = ST_DISP_WAIT;
      ST_DISP_WAIT: if (!enable) state_nxt = ST_SHUT_BL;
                    else if (tmr == T_DB) state_nxt = ST_RUN;
      ST_RUN:       if (!enable) state_nxt = ST_SHUT_BL;
      ST_SHUT_BL:   if (tmr == T_ED) state_nxt = ST_SHUT_DISP;
      ST_SHUT_DISP: if (tmr == T_ED) state_nxt = ST_OFF;
      default:      state_nxt = ST_OFF;
    endcase
    if (!armed) state_nxt = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
      armed <= 1'b0;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      tmr   <= (state_nxt != state) ? '0 : tmr + 32'd1;
    end
  end

  assign tft_en      = (state != ST_OFF);
  assign tft_display = (state inside {ST_DISP_WAIT, ST_RUN, ST_SHUT_BL});
  assign ready       = (state == ST_RUN);

  logic run, run_nxt, clk_on, half_end, rise_tick, fall_tick;
  logic [PDW-1:0] pdiv;

  assign run       = (state == ST_RUN);
  assign run_nxt   = (state_nxt == ST_RUN);
  assign clk_on    = (state == ST_DISP_WAIT) || run;
  assign half_end  = clk_on && (pdiv == PD_LAST);
  assign rise_tick = half_end && !tft_clk;
  assign fall_tick = half_end && tft_clk;

  // Pixel clock freezes during shutdown and parks low once OFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdiv    <= '0;
      tft_clk <= 1'b0;
    end else if (state_nxt == ST_OFF) begin
      pdiv    <= '0;
      tft_clk <= 1'b0;
    end else if (clk_on) begin
      pdiv <= half_end ? '0 : pdiv + 1'b1;
      if (half_end) tft_clk <= ~tft_clk;
    end
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, first_px, fmt_q;
  logic [7:0]    duty_q;
  rgb_t          px;

  assign active   = (h_cnt >= H_BLK) && (v_cnt >= V_BLK);
  assign first_px = (h_cnt == H_BLK) && (v_cnt == V_BLK);

  // Counters name the pixel presented at the next fall tick; its address
  // goes out on the rise tick before so fb_data has settled by then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      tft_de      <= 1'b0;
      px          <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      fb_addr     <= '0;
      fmt_q       <= 1'b0;
      duty_q      <= '0;
    end else if (!run_nxt) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      tft_de      <= 1'b0;
      px          <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (run && rise_tick && active)
        fb_addr <= first_px ? '0 : fb_addr + 1'b1;
      if (run && fall_tick) begin
        tft_de      <= active;
        vblank      <= (v_cnt < V_BLK);
        px          <= active ? px_expand(fmt_q, fb_data) : '0;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if ((h_cnt == '0) && (v_cnt == '0)) begin
          fmt_q  <= fmt;
          duty_q <= bl_duty;
        end
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign tft_r = px.r;
  assign tft_g = px.g;
  assign tft_b = px.b;

  lcd_pwm #(.PRESC(PWM_PRESC)) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .duty   (duty_q),
    .led_en (led_en)
  );

endmodule
